// File: rtl/cjtag_bridge_core.sv
// cJTAG (IEEE 1149.7 OScan1) to 4-wire JTAG bridge. TCKC/TMSC are oversampled on clk_i;
// escapes and the activation code are decoded, then each 3-bit OScan1 packet becomes one TCK cycle.
module cjtag_bridge_core #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic ntrst_i,
    input  logic tckc_i,
    input  logic tmsc_i,
    output logic tmsc_o,
    output logic tmsc_oen,
    output logic tck_o,
    output logic tms_o,
    output logic tdi_o,
    input  logic tdo_i,
    output logic online_o,
    output logic nsp_o
);

    typedef enum logic [1:0] {StOffline, StOac, StOscan1} state_e;

    // First-to-last bit order OAC, EC, CP = 0011 0001 0000
    localparam logic [11:0] ActivationCode = 12'h310;

    logic [SYNC_STAGES-1:0] tckc_sync_q;
    logic [SYNC_STAGES-1:0] tmsc_sync_q;
    logic [SYNC_STAGES-1:0] ntrst_sync_q;
    logic                   tckc_q;
    logic                   tmsc_q;

    logic tckc_s;
    logic tmsc_s;
    logic ntrst_s;
    logic tckc_rise;
    logic tckc_fall;
    logic tmsc_edge;
    logic link_reset;

    state_e      state_q;
    logic [3:0]  esc_cnt_q;
    logic [3:0]  bit_cnt_q;
    logic [11:0] oac_q;
    logic [1:0]  phase_q;
    logic        tck_q;
    logic        tms_q;
    logic        tdi_q;
    logic        tmsc_out_q;
    logic        oen_q;
    logic        online_q;
    logic        nsp_q;

    logic [11:0] oac_next;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tckc_sync_q  <= '0;
            tmsc_sync_q  <= '0;
            ntrst_sync_q <= '1;
            tckc_q       <= 1'b0;
            tmsc_q       <= 1'b0;
        end else begin
            tckc_sync_q  <= {tckc_sync_q[SYNC_STAGES-2:0], tckc_i};
            tmsc_sync_q  <= {tmsc_sync_q[SYNC_STAGES-2:0], tmsc_i};
            ntrst_sync_q <= {ntrst_sync_q[SYNC_STAGES-2:0], ntrst_i};
            tckc_q       <= tckc_sync_q[SYNC_STAGES-1];
            tmsc_q       <= tmsc_sync_q[SYNC_STAGES-1];
        end
    end

    always_comb begin
        tckc_s     = tckc_sync_q[SYNC_STAGES-1];
        tmsc_s     = tmsc_sync_q[SYNC_STAGES-1];
        ntrst_s    = ntrst_sync_q[SYNC_STAGES-1];
        tckc_rise  = tckc_s & ~tckc_q;
        tckc_fall  = ~tckc_s & tckc_q;
        tmsc_edge  = tmsc_s ^ tmsc_q;
        link_reset = rst_i | ~ntrst_s;
        oac_next   = {oac_q[10:0], tmsc_s};
    end

    always_ff @(posedge clk_i) begin
        if (link_reset) begin
            state_q    <= StOffline;
            esc_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            oac_q      <= '0;
            phase_q    <= '0;
            tck_q      <= 1'b0;
            tms_q      <= 1'b1;
            tdi_q      <= 1'b0;
            tmsc_out_q <= 1'b0;
            oen_q      <= 1'b1;
            online_q   <= 1'b0;
            nsp_q      <= 1'b0;
        end else begin
            if (tckc_fall) begin
                esc_cnt_q <= '0;
            end else if (tckc_s && tmsc_edge && esc_cnt_q != 4'd15) begin
                esc_cnt_q <= esc_cnt_q + 4'd1;
            end

            if (!oen_q) begin
                tmsc_out_q <= tdo_i;
            end

            if (tckc_fall && esc_cnt_q >= 4'd4) begin
                // Any escape abandons a partial packet and releases the pin
                tck_q   <= 1'b0;
                oen_q   <= 1'b1;
                phase_q <= '0;
                if (esc_cnt_q >= 4'd8) begin
                    state_q    <= StOffline;
                    bit_cnt_q  <= '0;
                    tms_q      <= 1'b1;
                    tdi_q      <= 1'b0;
                    tmsc_out_q <= 1'b0;
                    online_q   <= 1'b0;
                    nsp_q      <= 1'b0;
                end else if (esc_cnt_q >= 4'd6) begin
                    state_q   <= StOac;
                    bit_cnt_q <= '0;
                    online_q  <= 1'b0;
                    nsp_q     <= 1'b1;
                end else begin
                    state_q  <= StOffline;
                    online_q <= 1'b0;
                    nsp_q    <= 1'b0;
                end
            end else begin
                unique case (state_q)
                    StOffline: begin
                        tck_q <= 1'b0;
                        oen_q <= 1'b1;
                    end
                    StOac: begin
                        if (tckc_rise) begin
                            oac_q <= oac_next;
                            if (bit_cnt_q == 4'd11) begin
                                bit_cnt_q <= '0;
                                phase_q   <= '0;
                                if (oac_next == ActivationCode) begin
                                    state_q  <= StOscan1;
                                    online_q <= 1'b1;
                                end else begin
                                    state_q <= StOffline;
                                    nsp_q   <= 1'b0;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end
                        end
                    end
                    StOscan1: begin
                        // phase_q names the bit the next rise will carry
                        if (tckc_rise) begin
                            unique case (phase_q)
                                2'd0: begin
                                    tdi_q   <= ~tmsc_s;
                                    phase_q <= 2'd1;
                                end
                                2'd1: begin
                                    tms_q   <= tmsc_s;
                                    phase_q <= 2'd2;
                                end
                                default: begin
                                    tck_q   <= 1'b1;
                                    phase_q <= 2'd0;
                                end
                            endcase
                        end else if (tckc_fall) begin
                            if (phase_q == 2'd2) begin
                                oen_q      <= 1'b0;
                                tmsc_out_q <= tdo_i;
                            end else if (phase_q == 2'd0) begin
                                tck_q <= 1'b0;
                                oen_q <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q  <= StOffline;
                        online_q <= 1'b0;
                        nsp_q    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tmsc_o   = tmsc_out_q;
    assign tmsc_oen = oen_q;
    assign tck_o    = tck_q;
    assign tms_o    = tms_q;
    assign tdi_o    = tdi_q;
    assign online_o = online_q;
    assign nsp_o    = nsp_q;

endmodule

// File: tb/tb_cjtag_bridge_core.sv
// Directed bench for cjtag_bridge_core: a host drives TCKC/TMSC, a small TAP model
// answers on TDO with IDCODE 0x1DEAD3FF.
module tb_cjtag_bridge_core;

    localparam int H = 6;
    localparam logic [31:0] Idcode = 32'h1DEAD3FF;

    localparam logic [3:0] TapTlr = 4'd0, TapRti = 4'd1, TapSelDr = 4'd2, TapCapDr = 4'd3;
    localparam logic [3:0] TapShDr = 4'd4, TapEx1Dr = 4'd5, TapPDr = 4'd6, TapEx2Dr = 4'd7;
    localparam logic [3:0] TapUpDr = 4'd8, TapSelIr = 4'd9, TapCapIr = 4'd10, TapShIr = 4'd11;
    localparam logic [3:0] TapEx1Ir = 4'd12, TapPIr = 4'd13, TapEx2Ir = 4'd14, TapUpIr = 4'd15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ntrst = 1'b1;
    logic tckc = 1'b0;
    logic tmsc = 1'b0;
    logic tdo = 1'b0;
    logic tmsc_o, tmsc_oen, tck_o, tms_o, tdi_o, online_o, nsp_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cjtag_bridge_core #(.SYNC_STAGES(2)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .ntrst_i  (ntrst),
        .tckc_i   (tckc),
        .tmsc_i   (tmsc),
        .tmsc_o   (tmsc_o),
        .tmsc_oen (tmsc_oen),
        .tck_o    (tck_o),
        .tms_o    (tms_o),
        .tdi_o    (tdi_o),
        .tdo_i    (tdo),
        .online_o (online_o),
        .nsp_o    (nsp_o)
    );

    // Reference TAP: IDCODE selected after Test-Logic-Reset
    logic [3:0]  tap_st = TapTlr;
    logic [31:0] dr = '0;

    function automatic logic [3:0] tap_next(input logic [3:0] s, input logic m);
        case (s)
            TapTlr:   return m ? TapTlr   : TapRti;
            TapRti:   return m ? TapSelDr : TapRti;
            TapSelDr: return m ? TapSelIr : TapCapDr;
            TapCapDr: return m ? TapEx1Dr : TapShDr;
            TapShDr:  return m ? TapEx1Dr : TapShDr;
            TapEx1Dr: return m ? TapUpDr  : TapPDr;
            TapPDr:   return m ? TapEx2Dr : TapPDr;
            TapEx2Dr: return m ? TapUpDr  : TapShDr;
            TapUpDr:  return m ? TapSelDr : TapRti;
            TapSelIr: return m ? TapTlr   : TapCapIr;
            TapCapIr: return m ? TapEx1Ir : TapShIr;
            TapShIr:  return m ? TapEx1Ir : TapShIr;
            TapEx1Ir: return m ? TapUpIr  : TapPIr;
            TapPIr:   return m ? TapEx2Ir : TapPIr;
            TapEx2Ir: return m ? TapUpIr  : TapShIr;
            default:  return m ? TapSelDr : TapRti;
        endcase
    endfunction

    always @(posedge tck_o) begin
        if (tap_st == TapCapDr) dr <= Idcode;
        else if (tap_st == TapShDr) dr <= {tdi_o, dr[31:1]};
        tap_st <= tap_next(tap_st, tms_o);
    end

    always @(negedge tck_o) tdo <= (tap_st == TapShDr) ? dr[0] : 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic settle();
        repeat (H) @(negedge clk);
    endtask

    // One TCKC cycle; samples pin/oen just before the rise and tck_o just before the fall
    task automatic tckc_bit(input logic b, output logic s_tmsc, output logic s_oen,
                            output logic s_tck);
        tmsc = b;
        repeat (H) @(negedge clk);
        s_tmsc = tmsc_o;
        s_oen  = tmsc_oen;
        tckc   = 1'b1;
        repeat (H) @(negedge clk);
        s_tck  = tck_o;
        tckc   = 1'b0;
    endtask

    task automatic escape(input int n);
        settle();
        tckc = 1'b1;
        repeat (H) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            tmsc = ~tmsc;
            repeat (3) @(negedge clk);
        end
        repeat (H) @(negedge clk);
        tckc = 1'b0;
        settle();
    endtask

    task automatic send_bits(input logic [11:0] v);
        logic a, b, c;
        for (int i = 11; i >= 0; i--) tckc_bit(v[i], a, b, c);
        settle();
    endtask

    task automatic packet(input logic t_di, input logic t_ms, output logic s_tdo,
                          output logic s_oen, output logic s_tck);
        logic a, b, c;
        tckc_bit(~t_di, a, b, c);
        tckc_bit(t_ms, a, b, c);
        tckc_bit(1'b1, s_tdo, s_oen, s_tck);
    endtask

    initial begin
        logic        p_tdo, p_oen, p_tck;
        logic [31:0] word;
        logic        tms_seq [9];
        tms_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        word = '0;

        // Reset
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("rst_tms", tms_o, 1);
        check_eq("rst_tck", tck_o, 0);
        check_eq("rst_tdi", tdi_o, 0);
        check_eq("rst_tmsc_o", tmsc_o, 0);
        check_eq("rst_oen", tmsc_oen, 1);
        check_eq("rst_online", online_o, 0);
        check_eq("rst_nsp", nsp_o, 0);

        // Selection and activation
        escape(6);
        check_eq("sel_nsp", nsp_o, 1);
        check_eq("sel_online", online_o, 0);
        send_bits(12'h310);
        check_eq("act_online", online_o, 1);
        check_eq("act_nsp", nsp_o, 1);

        // Bad activation code
        escape(6);
        check_eq("bad_sel_nsp", nsp_o, 1);
        send_bits(12'hF10);
        check_eq("bad_online", online_o, 0);
        check_eq("bad_nsp", nsp_o, 0);

        // IDCODE read through OScan1
        escape(6);
        send_bits(12'h310);
        check_eq("id_online", online_o, 1);
        for (int i = 0; i < 9; i++) packet(1'b0, tms_seq[i], p_tdo, p_oen, p_tck);
        for (int i = 0; i < 32; i++) begin
            packet(i == 0, 1'b0, p_tdo, p_oen, p_tck);
            word[i] = p_tdo;
            if (i == 0) begin
                check_eq("ph2_oen", p_oen, 0);
                check_eq("ph2_tck", p_tck, 1);
                check_eq("ph0_tdi", tdi_o, 1);
                check_eq("ph1_tms", tms_o, 0);
            end
        end
        check_eq("idcode", word, Idcode);
        settle();
        check_eq("post_pkt_tck", tck_o, 0);
        check_eq("post_pkt_oen", tmsc_oen, 1);

        // Escapes from OSCAN1
        escape(2);
        check_eq("esc2_online", online_o, 1);
        escape(4);
        check_eq("esc4_online", online_o, 0);
        check_eq("esc4_nsp", nsp_o, 0);
        check_eq("esc4_tck", tck_o, 0);
        check_eq("esc4_oen", tmsc_oen, 1);
        escape(6);
        send_bits(12'h310);
        packet(1'b1, 1'b0, p_tdo, p_oen, p_tck);
        settle();
        check_eq("pre_esc8_tms", tms_o, 0);
        escape(8);
        check_eq("esc8_tms", tms_o, 1);
        check_eq("esc8_tdi", tdi_o, 0);
        check_eq("esc8_online", online_o, 0);
        check_eq("esc8_nsp", nsp_o, 0);
        check_eq("esc8_tck", tck_o, 0);
        check_eq("esc8_oen", tmsc_oen, 1);

        // ntrst mid-packet, with TCK high
        escape(6);
        send_bits(12'h310);
        tckc_bit(1'b1, p_tdo, p_oen, p_tck);
        tckc_bit(1'b0, p_tdo, p_oen, p_tck);
        tmsc = 1'b1;
        settle();
        tckc = 1'b1;
        settle();
        check_eq("pre_ntrst_tck", tck_o, 1);
        ntrst = 1'b0;
        repeat (4) @(negedge clk);
        ntrst = 1'b1;
        settle();
        check_eq("ntrst_tck", tck_o, 0);
        check_eq("ntrst_online", online_o, 0);
        check_eq("ntrst_nsp", nsp_o, 0);
        check_eq("ntrst_tms", tms_o, 1);
        tckc = 1'b0;
        escape(6);
        send_bits(12'h310);
        check_eq("resel_online", online_o, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
